lanzones_fetch: RTL and testbench

Instruction fetch stage of the lanzones core: owns the program counter, drives the single-port memory request handshake (RRdy/RAddr, response on RVld/RData), and buffers returned instruction words in a small FIFO that feeds decode over a valid/ready interface. Sits between the core's memory port and the decoder. It accepts control-flow redirects from execute and discards any stale in-flight response.

---
 rtl/lanzones_fetch.sv | 167 ++++++++++++++++
 tb/tb_lanzones_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lanzones_fetch.sv
// lanzones_fetch: instruction fetch stage of the lanzones core.
// Owns the program counter and issues one word request at a time on the
// RRdy/RAddr port. Returned words are buffered with their byte PC in a small
// FIFO that feeds decode over InstVld/InstRdy. Redirects from execute reload
// the PC, flush the FIFO and mark any in-flight response as stale.
// Optional feature: define LANZONES_FETCH_MISALIGN_EN to flag misaligned
// redirect targets on FetchErr (sticky) and stall fetch until an aligned
// redirect or reset. Without it the target's low two bits are ignored.
module lanzones_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        LEn,
    output logic        RRdy,
    output logic [31:0] RAddr,
    output logic        RWEn,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        InstVld,
    output logic [31:0] InstData,
    output logic [31:0] InstPc,
    input  logic        InstRdy,
    input  logic        RedirEn,
    input  logic [31:0] RedirPc,
    output logic        FetchErr
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic            drop_reg;
    logic            err_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem   [FIFO_DEPTH];

    logic            redir_bad;
    logic            err_next;
    logic [31:0]     redir_target;
    logic            push;
    logic            pop;
    logic            can_run;
    logic            idle_space;
    logic            resp_space;

    // Redirect targets are always word aligned inside the fetch stage.
    assign redir_target = {RedirPc[31:2], 2'b00};

`ifdef LANZONES_FETCH_MISALIGN_EN
    assign redir_bad = RedirEn && (RedirPc[1:0] != 2'b00);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^RedirPc[1:0];
    assign redir_bad        = 1'b0;
`endif

    // A redirect either sets (misaligned) or clears (aligned) the error.
    assign err_next = RedirEn ? redir_bad : err_reg;

    // Stale responses (drop flag or a coincident redirect) are never pushed,
    // and a pop in the redirect cycle is void because the FIFO is flushed.
    assign push       = (state_reg == RESP) && RVld && !drop_reg && !RedirEn;
    assign pop        = InstVld && InstRdy && !RedirEn;
    assign count_next = RedirEn ? '0 : (count_reg + CW'(push) - CW'(pop));
    assign can_run    = LEn && !err_next;
    // From IDLE nothing is outstanding, so only FIFO occupancy matters;
    // a redirect empties the FIFO in the same edge.
    assign idle_space = RedirEn || (count_reg < DEPTH_C);
    // After a response the slot is free again; look at the post-push/pop count.
    assign resp_space = count_next < DEPTH_C;

    assign RRdy     = (state_reg == REQ);
    assign RAddr    = {2'b00, pc_reg[31:2]};
    assign RWEn     = 1'b0;
    assign InstVld  = (count_reg != '0);
    assign InstData = data_mem[rd_ptr_reg];
    assign InstPc   = pc_mem[rd_ptr_reg];
    assign FetchErr = err_reg;

    // Request FSM, program counter, stale-response and error flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            drop_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (RedirEn) begin
                pc_reg <= redir_target;
            end else if (push) begin
                pc_reg <= pc_reg + 32'd4;
            end
            case (state_reg)
                IDLE: begin
                    if (can_run && idle_space) begin
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // The strobe has already gone out; its answer must be discarded.
                    state_reg <= RESP;
                    if (RedirEn) begin
                        drop_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (RVld) begin
                        drop_reg  <= 1'b0;
                        state_reg <= (can_run && resp_space) ? REQ : IDLE;
                    end else if (RedirEn) begin
                        drop_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect flushes by snapping read to write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (RedirEn) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    // FIFO storage: instruction word plus the byte PC it was fetched from.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr_reg] <= RData;
            pc_mem[wr_ptr_reg]   <= pc_reg;
        end
    end

endmodule

// File: tb/tb_lanzones_fetch.sv
// tb_lanzones_fetch: directed and randomized bench for lanzones_fetch.
// A word-level memory answers each request after a chosen latency, and a
// reference stream model predicts which byte PC decode must see next.
`timescale 1ns/1ps
module tb_lanzones_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn, LEn, RRdy, RWEn, RVld, InstVld, InstRdy, RedirEn, FetchErr;
    logic [31:0] RAddr, RData, InstData, InstPc, RedirPc;

    always #5 clk = ~clk;

    lanzones_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn), .LEn(LEn), .RRdy(RRdy), .RAddr(RAddr),
        .RWEn(RWEn), .RVld(RVld), .RData(RData), .InstVld(InstVld),
        .InstData(InstData), .InstPc(InstPc), .InstRdy(InstRdy),
        .RedirEn(RedirEn), .RedirPc(RedirPc), .FetchErr(FetchErr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // memory model state
    bit          mem_busy = 0;
    bit          mem_hold = 0;
    bit          stray    = 0;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          lat_max  = 0;

    // stream model state
    logic [31:0] exp_pc;
    bit          prev_stall = 0;
    logic [31:0] prev_pc, prev_data;

    logic [31:0] req_addr[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_data[$];
    int          dl_cyc[$];

    // Memory contents: word w holds {w, 7'h13} (0x13, 0x93, 0x113, ...).
    function automatic logic [31:0] memfn(input logic [31:0] waddr);
        return (waddr << 7) | 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_rrdy"},     RRdy,     32'd0);
        chk({t, "_raddr"},    RAddr,    RESET_PC >> 2);
        chk({t, "_rwen"},     RWEn,     32'd0);
        chk({t, "_instvld"},  InstVld,  32'd0);
        chk({t, "_instdata"}, InstData, 32'd0);
        chk({t, "_instpc"},   InstPc,   32'd0);
        chk({t, "_fetcherr"}, FetchErr, 32'd0);
    endtask

    // One clock cycle: observe outputs at the falling edge, answer memory,
    // apply this cycle's inputs and update the expected instruction stream.
    task automatic step(input bit rst_n, input bit len, input bit rdy,
                        input bit redir, input logic [31:0] rpc);
        bit busy_before;
        @(negedge clk);
        cyc++;
        chk("rwen_zero", RWEn, 32'd0);
`ifndef LANZONES_FETCH_MISALIGN_EN
        chk("fetcherr_zero", FetchErr, 32'd0);
`endif
        if (prev_stall) begin
            chk("stall_vld",  InstVld,  32'd1);
            chk("stall_pc",   InstPc,   prev_pc);
            chk("stall_data", InstData, prev_data);
        end
        busy_before = mem_busy;
        RVld  = 1'b0;
        RData = 32'h0;
        if (stray) begin
            RVld  = 1'b1;
            RData = 32'hDEAD_BEEF;
            stray = 0;
        end else if (mem_busy && !mem_hold) begin
            if (mem_delay == 0) begin
                RVld     = 1'b1;
                RData    = memfn(mem_addr);
                mem_busy = 0;
            end else begin
                mem_delay--;
            end
        end
        if (RRdy === 1'b1) begin
            chk("one_outstanding", busy_before, 32'd0);
            mem_busy  = 1;
            mem_addr  = RAddr;
            mem_delay = $urandom_range(0, lat_max);
            req_addr.push_back(RAddr);
        end
        rstn    = rst_n;
        LEn     = len;
        InstRdy = rdy;
        RedirEn = redir;
        RedirPc = rpc;
        if (!rst_n) begin
            mem_busy   = 0;
            exp_pc     = RESET_PC;
            prev_stall = 0;
        end else begin
            if (InstVld === 1'b1 && rdy && !redir) begin
                chk("deliver_pc",   InstPc,   exp_pc);
                chk("deliver_data", InstData, memfn(InstPc >> 2));
                dl_pc.push_back(InstPc);
                dl_data.push_back(InstData);
                dl_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) exp_pc = {rpc[31:2], 2'b00};
            prev_stall = (InstVld === 1'b1) && !rdy && !redir;
            prev_pc    = InstPc;
            prev_data  = InstData;
        end
    endtask

    task automatic reset_seq();
        lat_max  = 0;
        mem_hold = 0;
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        req_addr.delete();
        dl_pc.delete();
        dl_data.delete();
        dl_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, m;
        bit r_rst, r_len, r_rdy, r_redir;
        logic [31:0] tgt;
        rstn = 1'b0; LEn = 1'b0; InstRdy = 1'b0; RedirEn = 1'b0;
        RedirPc = 32'h0; RVld = 1'b0; RData = 32'h0;
        exp_pc = RESET_PC;

        // T1: reset values, then streaming fetch with decode always ready
        reset_seq();
        chk_reset_vals("t1_reset");
        c0 = cyc + 1;
        for (int i = 0; i < 40 && dl_pc.size() < 4; i++) step(1, 1, 1, 0, 32'h0);
        chk("t1_deliveries", dl_pc.size(), 32'd4);
        if (dl_pc.size() >= 4) begin
            chk("t1_first_latency", dl_cyc[0] - c0, 32'd3);
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", dl_data[i], 32'h13 + 32'h80 * i);
                chk("t1_pc", dl_pc[i], 32'd4 * i);
                if (i > 0) chk("t1_spacing", dl_cyc[i] - dl_cyc[i-1], 32'd2);
            end
        end

        // T2: decode stalled -> exactly two requests, then resume at word 2
        reset_seq();
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 32'h0);
        chk("t2_req_count", req_addr.size(), 32'd2);
        if (req_addr.size() >= 2) begin
            chk("t2_req0", req_addr[0], 32'd0);
            chk("t2_req1", req_addr[1], 32'd1);
        end
        chk("t2_full_vld", InstVld, 32'd1);
        n = req_addr.size();
        for (int i = 0; i < 10 && req_addr.size() == n; i++) step(1, 1, 1, 0, 32'h0);
        chk("t2_resumed", req_addr.size(), n + 1);
        if (req_addr.size() > n) chk("t2_resume_addr", req_addr[n], 32'd2);

        // T3: redirect coincident with the response for word 1
        reset_seq();
        for (int i = 0; i < 20 && req_addr.size() < 2; i++) step(1, 1, 0, 0, 32'h0);
        chk("t3_second_req", req_addr.size(), 32'd2);
        if (req_addr.size() >= 2) chk("t3_req1_addr", req_addr[1], 32'd1);
        step(1, 1, 0, 1, 32'h40);
        n = req_addr.size();
        m = dl_pc.size();
        step(1, 1, 1, 0, 32'h0);
        chk("t3_flushed", InstVld, 32'd0);
        for (int i = 0; i < 20 && dl_pc.size() == m; i++) step(1, 1, 1, 0, 32'h0);
        chk("t3_got_req", req_addr.size() > n, 32'd1);
        if (req_addr.size() > n) chk("t3_redir_addr", req_addr[n], 32'h10);
        chk("t3_got_inst", dl_pc.size() > m, 32'd1);
        if (dl_pc.size() > m) chk("t3_redir_pc", dl_pc[m], 32'h40);

        // T4: PC wrap from 0xFFFF_FFFC to 0
        reset_seq();
        step(1, 1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && dl_pc.size() < 2; i++) step(1, 1, 1, 0, 32'h0);
        chk("t4_deliveries", dl_pc.size(), 32'd2);
        if (req_addr.size() >= 2) begin
            chk("t4_req_top", req_addr[0], 32'h3FFF_FFFF);
            chk("t4_req_wrap", req_addr[1], 32'h0);
        end
        if (dl_pc.size() >= 2) begin
            chk("t4_pc_top", dl_pc[0], 32'hFFFF_FFFC);
            chk("t4_pc_wrap", dl_pc[1], 32'h0);
            chk("t4_data_wrap", dl_data[1], 32'h13);
        end

        // T5: reset while waiting for a response, then a stray RVld
        reset_seq();
        for (int i = 0; i < 20 && req_addr.size() < 2; i++) step(1, 1, 0, 0, 32'h0);
        mem_hold = 1;
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        chk("t5_buffered_vld", InstVld, 32'd1);
        step(0, 1, 0, 0, 32'h0);
        mem_hold = 0;
        stray    = 1;
        step(1, 0, 1, 0, 32'h0);
        chk_reset_vals("t5_reset");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 32'h0);
            chk("t5_stray_ignored", InstVld, 32'd0);
        end
        req_addr.delete();
        dl_pc.delete();
        for (int i = 0; i < 20 && dl_pc.size() == 0; i++) step(1, 1, 1, 0, 32'h0);
        if (req_addr.size() > 0) chk("t5_restart_addr", req_addr[0], RESET_PC >> 2);
        chk("t5_restart_inst", dl_pc.size() > 0, 32'd1);
        if (dl_pc.size() > 0) chk("t5_restart_pc", dl_pc[0], RESET_PC);

        // T6: misaligned redirect target
        reset_seq();
        step(1, 1, 1, 1, 32'h42);
        step(1, 1, 1, 0, 32'h0);
`ifdef LANZONES_FETCH_MISALIGN_EN
        chk("t6_err_set", FetchErr, 32'd1);
        chk("t6_no_rrdy", RRdy, 32'd0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 32'h0);
        chk("t6_err_sticky", FetchErr, 32'd1);
        chk("t6_no_req", req_addr.size(), 32'd0);
        step(1, 1, 1, 1, 32'h44);
        step(1, 1, 1, 0, 32'h0);
        chk("t6_err_clear", FetchErr, 32'd0);
        chk("t6_rrdy", RRdy, 32'd1);
        chk("t6_raddr", RAddr, 32'h11);
`else
        chk("t6_err_zero", FetchErr, 32'd0);
        chk("t6_rrdy", RRdy, 32'd1);
        chk("t6_raddr", RAddr, 32'h10);
`endif

        // Randomized: latency, enable, back-pressure, redirects, resets
        reset_seq();
        lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            r_rst   = ($urandom_range(0, 399) != 0);
            r_len   = ($urandom_range(0, 7) != 0);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 29) == 0);
            tgt     = $urandom();
            tgt[1:0] = 2'b00;
            step(r_rst, r_len, r_rdy, r_redir, tgt);
        end
        chk("rand_progress", dl_pc.size() > 100, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
